// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: saturating add/sub, logic ops, shifts, LHB and an
// iterative shift-add signed multiply, with registered result and {V,Z,N} flags.
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [SHW-1:0]   sh_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dst,
  output logic [2:0]       flags
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpNor = 4'd3;
  localparam logic [3:0] OpSll = 4'd4;
  localparam logic [3:0] OpSrl = 4'd5;
  localparam logic [3:0] OpSra = 4'd6;
  localparam logic [3:0] OpLhb = 4'd7;
  localparam logic [3:0] OpMul = 4'd8;

  localparam logic [WIDTH-1:0]   MaxPos  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] MaxPosW = {{WIDTH{1'b0}}, MaxPos};
  localparam logic [2*WIDTH-1:0] MinMagW = {{WIDTH{1'b0}}, MinNeg};
  localparam logic [SHW-1:0]     CntLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   dst_q, dst_d;
  logic               v_q, v_d, z_q, z_d, n_q, n_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res, abs0, abs1, mul_res;
  logic               upd_v, upd_z, upd_n, v_new, mul_ovf;
  logic               in_fire, out_fire, load_alu, load_mul;

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign flags     = {v_q, z_q, n_q};

  assign abs0 = src0[WIDTH-1] ? -src0 : src0;
  assign abs1 = src1[WIDTH-1] ? -src1 : src1;

  // Single-cycle ALU; sign-extended WIDTH+1 arithmetic so overflow never wraps.
  always_comb begin
    sum   = {src0[WIDTH-1], src0} + {src1[WIDTH-1], src1};
    diff  = {src0[WIDTH-1], src0} - {src1[WIDTH-1], src1};
    res   = src0;
    upd_v = 1'b0;
    upd_z = 1'b0;
    upd_n = 1'b0;
    v_new = 1'b0;
    case (op)
      OpAdd: begin
        upd_v = 1'b1; upd_z = 1'b1; upd_n = 1'b1;
        v_new = sum[WIDTH] ^ sum[WIDTH-1];
        res   = v_new ? (sum[WIDTH] ? MinNeg : MaxPos) : sum[WIDTH-1:0];
      end
      OpSub: begin
        upd_v = 1'b1; upd_z = 1'b1; upd_n = 1'b1;
        v_new = diff[WIDTH] ^ diff[WIDTH-1];
        res   = v_new ? (diff[WIDTH] ? MinNeg : MaxPos) : diff[WIDTH-1:0];
      end
      OpAnd: begin res = src0 & src1;              upd_z = 1'b1; end
      OpNor: begin res = ~(src0 | src1);           upd_z = 1'b1; end
      OpSll: begin res = src0 << sh_amt;           upd_z = 1'b1; end
      OpSrl: begin res = src0 >> sh_amt;           upd_z = 1'b1; end
      OpSra: begin res = $signed(src0) >>> sh_amt; upd_z = 1'b1; end
      OpLhb: res = {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]};
      default: res = src0;
    endcase
  end

  // Product magnitude fits in 2*WIDTH bits; saturate asymmetrically by sign.
  always_comb begin
    mul_ovf = neg_q ? (acc_q > MinMagW) : (acc_q > MaxPosW);
    if (mul_ovf) mul_res = neg_q ? MinNeg : MaxPos;
    else         mul_res = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    load_alu = 1'b0;
    load_mul = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_fire) begin
          if (op == OpMul) begin
            state_d  = StMul;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, abs0};
            mplier_d = abs1;
            neg_d    = src0[WIDTH-1] ^ src1[WIDTH-1];
          end else begin
            load_alu = 1'b1;
          end
        end
      end
      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StDone: begin
        // Hold the product until the previous result has been taken.
        if (!out_valid_q || out_ready) begin
          load_mul = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dst_d = dst_q;
    v_d   = v_q;
    z_d   = z_q;
    n_d   = n_q;
    if (load_alu) begin
      dst_d = res;
      if (upd_v) v_d = v_new;
      if (upd_z) z_d = ~|res;
      if (upd_n) n_d = res[WIDTH-1];
    end else if (load_mul) begin
      dst_d = mul_res;
      v_d   = mul_ovf;
      z_d   = ~|mul_res;
      n_d   = mul_res[WIDTH-1];
    end
    if (load_alu || load_mul) out_valid_d = 1'b1;
    else if (out_fire)        out_valid_d = 1'b0;
    else                      out_valid_d = out_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      dst_q       <= '0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      dst_q       <= dst_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] src0, src1;
  logic [3:0]  sh_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dst;
  logic [2:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src0      (src0),
    .src1      (src1),
    .sh_amt    (sh_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dst       (dst),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for a single edge; caller knows in_ready is high.
  task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s);
    op = o; src0 = a; src1 = b; sh_amt = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] d, input logic [2:0] f);
    check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, " dst"}, 32'(dst), 32'(d));
    check_eq({tag, " flags"}, 32'(flags), 32'(f));
  endtask

  // Accept a MUL and measure accept-to-valid latency and in_ready behaviour.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic [2:0] f);
    int lat;
    logic ir_seen;
    lat = 0;
    ir_seen = 1'b0;
    do_op(4'd8, a, b, 4'd0);
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_seen = 1'b1;
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'd17);
    check_eq({tag, " in_ready low"}, 32'(ir_seen), 32'd0);
    check_res(tag, d, f);
  endtask

  initial begin
    logic late;
    rst = 1'b1; in_valid = 1'b0; op = '0; src0 = '0; src1 = '0; sh_amt = '0;
    out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("reset valid", 32'(out_valid), 32'd0);
    check_eq("reset dst", 32'(dst), 32'd0);
    check_eq("reset flags", 32'(flags), 32'd0);
    check_eq("reset in_ready", 32'(in_ready), 32'd1);

    do_op(4'd0, 16'h7FFF, 16'h0001, 4'd0); check_res("add sat pos", 16'h7FFF, 3'b100);
    do_op(4'd0, 16'h8000, 16'hFFFF, 4'd0); check_res("add sat neg", 16'h8000, 3'b101);
    do_op(4'd1, 16'h0000, 16'h8000, 4'd0); check_res("sub minneg", 16'h7FFF, 3'b100);
    do_op(4'd2, 16'h00F0, 16'h0F00, 4'd0); check_res("and zero", 16'h0000, 3'b110);
    do_op(4'd6, 16'h8000, 16'h0000, 4'd11); check_res("sra 11", 16'hFFF0, 3'b100);
    do_op(4'd6, 16'h8000, 16'h0000, 4'd15); check_res("sra 15", 16'hFFFF, 3'b100);
    do_op(4'd5, 16'h8000, 16'h0000, 4'd15); check_res("srl 15", 16'h0001, 3'b100);
    do_op(4'd4, 16'h0003, 16'h0000, 4'd4);  check_res("sll 4", 16'h0030, 3'b100);
    do_op(4'd7, 16'h1234, 16'hABCD, 4'd0);  check_res("lhb", 16'hCD34, 3'b100);
    do_op(4'd9, 16'h0000, 16'h5555, 4'd0);  check_res("nop", 16'h0000, 3'b100);

    do_mul("mul neg", 16'hFFFD, 16'h0007, 16'hFFEB, 3'b001);
    do_mul("mul sat", 16'h0100, 16'h0100, 16'h7FFF, 3'b100);

    // Backpressure then simultaneous drain/accept.
    do_op(4'd0, 16'h0001, 16'h0002, 4'd0);
    out_ready = 1'b0;
    tick(); tick(); tick();
    check_res("bp hold", 16'h0003, 3'b000);
    check_eq("bp in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    do_op(4'd3, 16'h00FF, 16'h0F00, 4'd0);
    check_res("nor replace", 16'hF000, 3'b000);

    // Reset five cycles into a multiply.
    do_op(4'd8, 16'h0002, 16'h0003, 4'd0);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst mul valid", 32'(out_valid), 32'd0);
    check_eq("rst mul dst", 32'(dst), 32'd0);
    check_eq("rst mul flags", 32'(flags), 32'd0);
    check_eq("rst mul in_ready", 32'(in_ready), 32'd1);
    late = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) late = 1'b1;
      tick();
    end
    check_eq("no late mul", 32'(late), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the datapath's combinational 16-bit ALU. Accepts one operation per transfer on a valid/ready input, registers the result and V/Z/N flags, and presents them on a valid/ready output. It adds a WIDTH parameter, an iterative saturating signed multiply, an internal flags register, and an arithmetic right shift that is correct for every shift amount. It sits in the EX stage between operand forwarding and the EX/MEM pipeline register.

## Interface

Parameters:
- WIDTH, 16, data width; must be a power of two, at least 8.
- SHW, log2(WIDTH), width of the shift-amount field.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, an operation is offered.
- in_ready, output, 1, the block can accept an operation this cycle.
- op, input, 4, operation code: ADD=0, SUB=1, AND=2, NOR=3, SLL=4, SRL=5, SRA=6, LHB=7, MUL=8; 9–15 are NOP.
- src0, input, WIDTH, operand A.
- src1, input, WIDTH, operand B.
- sh_amt, input, SHW, shift amount.
- out_valid, output, 1, result is valid.
- out_ready, input, 1, downstream accepts the result.
- dst, output, WIDTH, registered result.
- flags, output, 3, {V,Z,N}, registered flags.

## Operation

- A transfer occurs when in_valid and in_ready are both high at a rising edge. Operands and op are captured at that edge.
- ADD and SUB compute the exact signed result in WIDTH+1 bits, then saturate:
  - above 2^(WIDTH-1)-1 → 0x7FFF (for WIDTH=16), V=1;
  - below -2^(WIDTH-1) → 0x8000, V=1;
  - otherwise V=0.
  - SUB with src1 = most-negative value saturates correctly; there is no two's-complement wrap.
- AND gives src0&src1; NOR gives ~(src0|src1).
- SLL and SRL are logical shifts by sh_amt.
- SRA replicates src0[WIDTH-1] into the vacated bits for every sh_amt from 0 to WIDTH-1.
- LHB gives {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]}.
- MUL is a signed multiply:
  - Take the magnitudes of both operands.
  - Shift-add one bit per cycle for WIDTH cycles into a 2·WIDTH-bit accumulator.
  - Apply the sign, then saturate to WIDTH bits with the same rule as ADD, setting V.
- NOP passes src0 to dst and leaves all flags unchanged.
- Flag update rules:
  - ADD, SUB, MUL update V, Z and N.
  - AND, NOR, SLL, SRL, SRA update Z only; V and N hold.
  - LHB and NOP update no flags.
  - Z is the NOR of the saturated dst. N is dst[WIDTH-1].
- State machine:
  - IDLE: in_ready = !out_valid || out_ready.
    - Accepting a non-MUL op loads dst/flags and sets out_valid; state stays IDLE.
    - Accepting MUL goes to MUL.
  - MUL: in_ready=0. A counter runs 0..WIDTH-1. On the final iteration go to DONE.
  - DONE: in_ready=0. The edge in DONE writes dst/flags, sets out_valid and returns to IDLE. If out_valid is still high from a previous op, the block stays in DONE until out_ready is seen.
- Output handshake: out_valid falls at the edge where out_valid && out_ready, unless a new result loads at that same edge. dst and flags are stable while out_valid=1 and out_ready=0.

## Timing

- Reset values: out_valid=0, dst=0, flags=3'b000, state IDLE, MUL counter 0. in_ready=1 in the first cycle after reset.
- Latency for non-MUL ops: accept at edge k, out_valid=1 after edge k. Throughput is one op per cycle while out_ready=1.
- Latency for MUL: accept at edge k, out_valid=1 after edge k+WIDTH+1, i.e. 17 cycles for WIDTH=16. in_ready stays low for WIDTH+1 cycles.
- Simultaneous output drain and input accept in IDLE: the new result replaces the old one, and out_valid stays 1.
- A reset asserted mid-MUL aborts the multiply. No result is produced, and all outputs return to their reset values at that edge.
- Flags are applied in acceptance order, so a younger op sees the flags left by the older op.

## Test plan

- ADD 0x7FFF + 0x0001 with out_ready=1 → next cycle dst=0x7FFF, flags V=1,Z=0,N=0. ADD 0x8000 + 0xFFFF → dst=0x8000, V=1, N=1.
- SUB 0x0000 − 0x8000 → dst=0x7FFF, V=1. Then AND 0x00F0 & 0x0F00 → dst=0x0000, Z=1, with V=1 and N=0 held.
- SRA 0x8000 by 11 → 0xFFF0. SRA 0x8000 by 15 → 0xFFFF. SRL 0x8000 by 15 → 0x0001. LHB src0=0x1234, src1=0xABCD → 0xCD34, flags unchanged.
- MUL 0xFFFD × 0x0007 → dst=0xFFEB, N=1, V=0, out_valid exactly 17 cycles after accept with in_ready low throughout. MUL 0x0100 × 0x0100 → 0x7FFF, V=1.
- Backpressure: hold out_ready=0 after an ADD → dst/flags stable, in_ready=0. Raise out_ready with in_valid=1 (NOR) → the NOR result loads in the same edge and out_valid stays 1.
- Assert rst 5 cycles into a MUL → out_valid=0, dst=0, flags=0 next cycle, in_ready=1. No late MUL result appears.
